sfx_arbiter: RTL

- Shares one piezo/speaker tone output between the game's sound-event requesters: game over, point scored, paddle hit, wall bounce.
- Sits beside the pong game logic. It takes single-cycle event pulses from the game logic and drives a square wave on one GPIO pin.
- Each tone plays for a fixed duration, followed by a silent gap. When several requests are pending, a fixed-priority scheduler chooses which one plays next.

---
 rtl/sfx_arbiter_if.sv | 21 ++
 rtl/sfx_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/sfx_arbiter_if.sv
// Sound-event bus between the pong game logic (master) and the tone arbiter (slave).
interface sfx_arbiter_if;
  logic       mute;
  logic       req_over;
  logic       req_score;
  logic       req_paddle;
  logic       req_wall;
  logic       tone_out;
  logic       busy;
  logic [1:0] active_id;

  modport master (
    output mute, req_over, req_score, req_paddle, req_wall,
    input  tone_out, busy, active_id
  );

  modport slave (
    input  mute, req_over, req_score, req_paddle, req_wall,
    output tone_out, busy, active_id
  );
endinterface

// File: rtl/sfx_arbiter.sv
// Fixed-priority sound-effect arbiter: latches event pulses, plays one square-wave
// tone at a time for a fixed duration, then holds a silent gap before the next grant.
module sfx_arbiter #(
  parameter int unsigned HALF_OVER   = 52448,
  parameter int unsigned HALF_SCORE  = 13112,
  parameter int unsigned HALF_PADDLE = 26224,
  parameter int unsigned HALF_WALL   = 39336,
  parameter int unsigned DUR_OVER    = 12_587_500,
  parameter int unsigned DUR_SCORE   = 7_552_500,
  parameter int unsigned DUR_PADDLE  = 2_517_500,
  parameter int unsigned DUR_WALL    = 1_258_750,
  parameter int unsigned GAP_CYCLES  = 251_750
) (
  input  logic         clk_0,
  input  logic         rst,
  sfx_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

  localparam logic [15:0] L_HALF_OVER   = 16'(HALF_OVER - 1);
  localparam logic [15:0] L_HALF_SCORE  = 16'(HALF_SCORE - 1);
  localparam logic [15:0] L_HALF_PADDLE = 16'(HALF_PADDLE - 1);
  localparam logic [15:0] L_HALF_WALL   = 16'(HALF_WALL - 1);
  localparam logic [23:0] L_DUR_OVER    = 24'(DUR_OVER - 1);
  localparam logic [23:0] L_DUR_SCORE   = 24'(DUR_SCORE - 1);
  localparam logic [23:0] L_DUR_PADDLE  = 24'(DUR_PADDLE - 1);
  localparam logic [23:0] L_DUR_WALL    = 24'(DUR_WALL - 1);
  localparam logic [17:0] L_GAP_LAST    = 18'(GAP_CYCLES - 1);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_pending, w_pending_nxt;
  logic [23:0] r_dur, w_dur_nxt;
  logic [15:0] r_div, w_div_nxt;
  logic [17:0] r_gap, w_gap_nxt;
  logic        r_tone, w_tone_nxt;
  logic [1:0]  r_active_id, w_id_nxt;

  logic [3:0]  w_req;
  logic        w_any;
  logic [1:0]  w_gid;
  logic        w_grant;
  logic [15:0] w_half_last;
  logic [23:0] w_dur_last;

  assign w_req = {bus.req_over, bus.req_score, bus.req_paddle, bus.req_wall};
  assign w_any = |r_pending;

  always_comb begin
    w_gid = 2'd0;
    if (r_pending[3])      w_gid = 2'd3;
    else if (r_pending[2]) w_gid = 2'd2;
    else if (r_pending[1]) w_gid = 2'd1;
  end

  always_comb begin
    case (r_active_id)
      2'd3:    begin w_half_last = L_HALF_OVER;   w_dur_last = L_DUR_OVER;   end
      2'd2:    begin w_half_last = L_HALF_SCORE;  w_dur_last = L_DUR_SCORE;  end
      2'd1:    begin w_half_last = L_HALF_PADDLE; w_dur_last = L_DUR_PADDLE; end
      default: begin w_half_last = L_HALF_WALL;   w_dur_last = L_DUR_WALL;   end
    endcase
  end

  always_ff @(posedge clk_0) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pending   <= '0;
      r_dur       <= '0;
      r_div       <= '0;
      r_gap       <= '0;
      r_tone      <= 1'b0;
      r_active_id <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pending   <= w_pending_nxt;
      r_dur       <= w_dur_nxt;
      r_div       <= w_div_nxt;
      r_gap       <= w_gap_nxt;
      r_tone      <= w_tone_nxt;
      r_active_id <= w_id_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending | w_req;
    w_dur_nxt     = r_dur;
    w_div_nxt     = r_div;
    w_gap_nxt     = r_gap;
    w_tone_nxt    = r_tone;
    w_id_nxt      = r_active_id;
    w_grant       = 1'b0;

    case (r_state)
      S_IDLE: w_grant = w_any;
      S_PLAY: begin
        if (r_dur == w_dur_last) begin
          w_state_nxt = S_GAP;
          w_tone_nxt  = 1'b0;
          w_dur_nxt   = '0;
          w_div_nxt   = '0;
          w_gap_nxt   = '0;
        end else begin
          w_dur_nxt = r_dur + 24'd1;
          if (r_div == w_half_last) begin
            w_div_nxt  = '0;
            w_tone_nxt = ~r_tone;
          end else begin
            w_div_nxt = r_div + 16'd1;
          end
        end
      end
      S_GAP: begin
        if (r_gap == L_GAP_LAST) begin
          w_gap_nxt = '0;
          if (w_any) w_grant = 1'b1;
          else       w_state_nxt = S_IDLE;
        end else begin
          w_gap_nxt = r_gap + 18'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // A same-cycle request for the granted id keeps its bit set so it replays.
    if (w_grant) begin
      w_state_nxt            = S_PLAY;
      w_id_nxt               = w_gid;
      w_dur_nxt              = '0;
      w_div_nxt              = '0;
      w_gap_nxt              = '0;
      w_tone_nxt             = 1'b1;
      w_pending_nxt[w_gid]   = w_req[w_gid];
    end

    if (bus.mute) begin
      w_state_nxt   = S_IDLE;
      w_pending_nxt = '0;
      w_dur_nxt     = '0;
      w_div_nxt     = '0;
      w_gap_nxt     = '0;
      w_tone_nxt    = 1'b0;
      w_id_nxt      = r_active_id;
    end
  end

  assign bus.tone_out  = r_tone;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.active_id = r_active_id;

endmodule
